// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic-light controller: round-robin green phases driven by car sensors,
// with min/max green, yellow and all-red clearance timing plus a parade (hold) mode.
module traffic_phase_ctrl #(
    parameter int N_PH        = 4,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 60,
    parameter int T_YELLOW    = 20,
    parameter int T_ALLRED    = 3,
    parameter int PARADE_PH   = 1,
    localparam int PH_W       = $clog2(N_PH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PH-1:0]     car_req,
    input  logic                parade,
    input  logic                resume,
    output logic [2*N_PH-1:0]   lights,
    output logic [PH_W-1:0]     phase,
    output logic [1:0]          fsm_st,
    output logic [CNT_W-1:0]    tmr
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_PARADE = 2'd3
    } st_e;

    localparam logic [CNT_W-1:0] MIN_GREEN_M1 = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_GREEN_M1 = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1    = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] TMR_MAX      = '1;
    localparam logic [PH_W-1:0]  PARADE_IDX   = PH_W'(PARADE_PH);

    st_e                 st_q, st_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]    tmr_q;
    logic [2*N_PH-1:0]   lights_q;
    logic                mode_q, mode_d;
    logic                other_req;
    logic [PH_W-1:0]     next_ph;

    // Lamp pattern for a given state/phase; lights are registered from the next state.
    function automatic logic [2*N_PH-1:0] decode(input st_e st, input logic [PH_W-1:0] ph);
        decode = '0;
        case (st)
            ST_GREEN:  decode[2*int'(ph) +: 2] = 2'b10;
            ST_YELLOW: decode[2*int'(ph) +: 2] = 2'b01;
            ST_PARADE: decode[2*PARADE_PH +: 2] = 2'b10;
            default:   decode = '0;
        endcase
    endfunction

    // Round-robin search starting after the current phase; falls back to phase+1.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        other_req = 1'b0;
        next_ph   = PH_W'((int'(phase_q) + 1) % N_PH);
        for (int i = 0; i < N_PH; i++) begin
            if (i != int'(phase_q) && car_req[i]) other_req = 1'b1;
        end
        for (int k = N_PH - 1; k >= 1; k--) begin
            if (car_req[(int'(phase_q) + k) % N_PH]) next_ph = PH_W'((int'(phase_q) + k) % N_PH);
        end
    end

    always_comb begin
        mode_d  = parade ? 1'b1 : (resume ? 1'b0 : mode_q);
        st_d    = st_q;
        phase_d = phase_q;
        case (st_q)
            ST_GREEN: begin
                if (mode_q && phase_q == PARADE_IDX) begin
                    st_d = ST_PARADE;
                end else if (mode_q ||
                             (other_req && tmr_q >= MIN_GREEN_M1 && !car_req[phase_q]) ||
                             (other_req && tmr_q >= MAX_GREEN_M1)) begin
                    st_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (tmr_q == YELLOW_M1) st_d = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (tmr_q == ALLRED_M1) begin
                    if (mode_q) begin
                        st_d    = ST_PARADE;
                        phase_d = PARADE_IDX;
                    end else begin
                        st_d    = ST_GREEN;
                        phase_d = next_ph;
                    end
                end
            end
            ST_PARADE: begin
                if (!mode_q) st_d = ST_YELLOW;
            end
            default: st_d = ST_GREEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_GREEN;
            phase_q  <= '0;
            tmr_q    <= '0;
            mode_q   <= 1'b0;
            lights_q <= decode(ST_GREEN, '0);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            st_q     <= st_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            lights_q <= decode(st_d, phase_d);
            if (st_d != st_q)        tmr_q <= '0;
            else if (tmr_q != TMR_MAX) tmr_q <= tmr_q + 1'b1;
        end
    end

    assign lights = lights_q;
    assign phase  = phase_q;
    assign fsm_st = st_q;
    assign tmr    = tmr_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the lamp/state outputs.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] car_req = '0;
    logic       parade = 1'b0;
    logic       resume = 1'b0;
    logic [7:0] lights;
    logic [1:0] phase;
    logic [1:0] fsm_st;
    logic [7:0] tmr;

    traffic_phase_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .car_req(car_req),
        .parade (parade),
        .resume (resume),
        .lights (lights),
        .phase  (phase),
        .fsm_st (fsm_st),
        .tmr    (tmr)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; follows rst asynchronously like the DUT.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int         epoch;
        int         cyc;
        logic [7:0] lights;
        logic [1:0] st;
        logic [1:0] ph;
        int         tmr;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    epoch = 0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_at(input int c, input logic [7:0] l, input logic [1:0] s,
                             input logic [1:0] p, input int t, input string n);
        exp_t e;
        e.epoch  = epoch;
        e.cyc    = c;
        e.lights = l;
        e.st     = s;
        e.ph     = p;
        e.tmr    = t;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_scenario(input logic [3:0] req);
        epoch++;
        rst     = 1'b1;
        car_req = req;
        parade  = 1'b0;
        resume  = 1'b0;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares the queue head when its epoch/cycle stamp comes round.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].epoch < epoch || (exp_q[0].epoch == epoch && exp_q[0].cyc < cyc)) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation at cycle %0d never sampled", name_q[0], exp_q[0].cyc);
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end else if (exp_q[0].epoch == epoch && exp_q[0].cyc == cyc) begin
                check({name_q[0], ".lights"}, int'(lights), int'(exp_q[0].lights));
                check({name_q[0], ".fsm_st"}, int'(fsm_st), int'(exp_q[0].st));
                check({name_q[0], ".phase"},  int'(phase),  int'(exp_q[0].ph));
                check({name_q[0], ".tmr"},    int'(tmr),    exp_q[0].tmr);
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end
    end

    initial begin
        // 1: no requests, green rests on approach 0; timer saturates.
        start_scenario(4'b0000);
        expect_at(0,    8'h02, 2'd0, 2'd0, 0,   "idle_reset");
        expect_at(9,    8'h02, 2'd0, 2'd0, 9,   "idle_c9");
        expect_at(255,  8'h02, 2'd0, 2'd0, 255, "idle_tmr_max");
        expect_at(256,  8'h02, 2'd0, 2'd0, 255, "idle_tmr_sat");
        expect_at(1000, 8'h02, 2'd0, 2'd0, 255, "idle_c1000");
        release_rst();
        goto(1001);

        // 2: request on approach 2 only, then 1001 while green on 2.
        start_scenario(4'b0100);
        expect_at(9,  8'h02, 2'd0, 2'd0, 9,  "minG_last_green");
        expect_at(10, 8'h01, 2'd1, 2'd0, 0,  "minG_yellow_start");
        expect_at(29, 8'h01, 2'd1, 2'd0, 19, "minG_yellow_end");
        expect_at(30, 8'h00, 2'd2, 2'd0, 0,  "minG_allred_start");
        expect_at(32, 8'h00, 2'd2, 2'd0, 2,  "minG_allred_end");
        expect_at(33, 8'h20, 2'd0, 2'd2, 0,  "minG_green2");
        expect_at(42, 8'h20, 2'd0, 2'd2, 9,  "rr_last_green2");
        expect_at(43, 8'h10, 2'd1, 2'd2, 0,  "rr_yellow2");
        expect_at(63, 8'h00, 2'd2, 2'd2, 0,  "rr_allred");
        expect_at(66, 8'h80, 2'd0, 2'd3, 0,  "rr_green3");
        release_rst();
        goto(33);
        car_req = 4'b1001;
        goto(67);

        // 3: current approach keeps requesting -> max green; search wraps to 0.
        start_scenario(4'b0011);
        expect_at(59,  8'h02, 2'd0, 2'd0, 59, "maxG_last_green0");
        expect_at(60,  8'h01, 2'd1, 2'd0, 0,  "maxG_yellow0");
        expect_at(83,  8'h08, 2'd0, 2'd1, 0,  "maxG_green1");
        expect_at(143, 8'h04, 2'd1, 2'd1, 0,  "maxG_yellow1");
        expect_at(166, 8'h02, 2'd0, 2'd0, 0,  "wrap_green0");
        release_rst();
        goto(167);

        // 5: parade pulse, hold, resume; no requests -> phase+1 fallback.
        start_scenario(4'b0000);
        expect_at(3,  8'h02, 2'd0, 2'd0, 3,  "par_green0");
        expect_at(4,  8'h01, 2'd1, 2'd0, 0,  "par_yellow0");
        expect_at(23, 8'h01, 2'd1, 2'd0, 19, "par_yellow0_end");
        expect_at(24, 8'h00, 2'd2, 2'd0, 0,  "par_allred");
        expect_at(27, 8'h08, 2'd3, 2'd1, 0,  "par_hold");
        expect_at(41, 8'h08, 2'd3, 2'd1, 14, "par_hold_late");
        expect_at(42, 8'h04, 2'd1, 2'd1, 0,  "par_exit_yellow1");
        expect_at(62, 8'h00, 2'd2, 2'd1, 0,  "par_exit_allred");
        expect_at(65, 8'h20, 2'd0, 2'd2, 0,  "par_exit_green2");
        release_rst();
        goto(2);
        parade = 1'b1;
        goto(3);
        parade = 1'b0;
        goto(40);
        resume = 1'b1;
        goto(41);
        resume = 1'b0;
        goto(66);

        // 6: parade+resume together -> parade; then reset mid-yellow.
        start_scenario(4'b0000);
        expect_at(4,  8'h01, 2'd1, 2'd0, 0, "both_yellow0");
        expect_at(27, 8'h08, 2'd3, 2'd1, 0, "both_parade");
        expect_at(32, 8'h04, 2'd1, 2'd1, 0, "both_exit_yellow1");
        expect_at(38, 8'h04, 2'd1, 2'd1, 6, "both_mid_yellow");
        release_rst();
        goto(2);
        parade = 1'b1;
        resume = 1'b1;
        goto(3);
        parade = 1'b0;
        resume = 1'b0;
        goto(30);
        resume = 1'b1;
        goto(31);
        resume = 1'b0;
        goto(38);
        @(negedge clk);
        #1;
        epoch++;
        expect_at(0, 8'h02, 2'd0, 2'd0, 0, "rst_mid_yellow");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        check("queue_drained", exp_q.size(), 0);
        while (exp_q.size() > 0) begin
            $display("FAIL %s: expectation at cycle %0d left unchecked", name_q[0], exp_q[0].cyc);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
